// File: rtl/key_schedule_buffer.sv
// key_schedule_buffer
// Iterative AES-128 key expansion into an 11-entry round-key bank, with a
// registered read port for the round stages.
// Optional feature macro: KEY_SCHED_INV_PORT_EN adds the invRoundKey read port
// (bank[NUM_ROUNDS - roundIndex]) for the inverse round pipeline.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | reset state, bank empty, ready to accept a cipher key
// EXPAND | writing one round key per clock into bank[round]
// DONE   | bank holds the full schedule of the last accepted key

module key_schedule_buffer #(
   parameter int NUM_ROUNDS = 10,
   parameter int KEY_WIDTH  = 128
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 keyValid,
   input  logic [KEY_WIDTH-1:0] keyIn,
   output logic                 loadReady,
   output logic                 keysReady,
   input  logic [3:0]           roundIndex,
`ifdef KEY_SCHED_INV_PORT_EN
   output logic [KEY_WIDTH-1:0] invRoundKey,
`endif
   output logic [KEY_WIDTH-1:0] roundKey
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   // AES forward S-box, byte 0x00 in the most-significant position.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [10:0] pos;
      pos = 11'd2040 - {a, 3'b000};
      return SBOX_TABLE[pos +: 8];
   endfunction

   state_t               state;
   logic [3:0]           round;
   logic [7:0]           rcon;
   logic [7:0]           rcon_next;
   logic [KEY_WIDTH-1:0] bank [0:NUM_ROUNDS];
   // Copy of bank[round-1]; avoids an 11:1 mux in front of the S-boxes.
   logic [KEY_WIDTH-1:0] cur_key;
   logic [KEY_WIDTH-1:0] next_key;
   logic [31:0]          w0, w1, w2, w3;
   logic [31:0]          rot_word, sub_word;
   logic [31:0]          n0, n1, n2, n3;

   // One AES-128 expansion step from cur_key using the current rcon.
   always_comb begin
      w0       = cur_key[127:96];
      w1       = cur_key[95:64];
      w2       = cur_key[63:32];
      w3       = cur_key[31:0];
      rot_word = {w3[23:0], w3[31:24]};
      sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                  sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
      n0       = w0 ^ sub_word ^ {rcon, 24'h0};
      n1       = w1 ^ n0;
      n2       = w2 ^ n1;
      n3       = w3 ^ n2;
      next_key = {n0, n1, n2, n3};
      rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
   end

   // Sequencer: load, iterate one round key per clock, flag completion.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         round     <= 4'd0;
         rcon      <= 8'h01;
         cur_key   <= '0;
         keysReady <= 1'b0;
         loadReady <= 1'b1;
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            bank[i] <= '0;
         end
      end else begin
         case (state)
            IDLE, DONE: begin
               if (keyValid) begin
                  bank[0]   <= keyIn;
                  cur_key   <= keyIn;
                  round     <= 4'd1;
                  rcon      <= 8'h01;
                  keysReady <= 1'b0;
                  loadReady <= 1'b0;
                  state     <= EXPAND;
               end
            end
            EXPAND: begin
               bank[round] <= next_key;
               cur_key     <= next_key;
               rcon        <= rcon_next;
               if (round == LAST_ROUND) begin
                  keysReady <= 1'b1;
                  loadReady <= 1'b1;
                  state     <= DONE;
               end else begin
                  round <= round + 4'd1;
               end
            end
            default: begin
               state     <= IDLE;
               loadReady <= 1'b1;
               keysReady <= 1'b0;
            end
         endcase
      end
   end

   // Registered read port; out-of-range selects return zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         roundKey <= '0;
      end else if (roundIndex <= LAST_ROUND) begin
         roundKey <= bank[roundIndex];
      end else begin
         roundKey <= '0;
      end
   end

`ifdef KEY_SCHED_INV_PORT_EN
   logic [3:0] inv_index;
   assign inv_index = LAST_ROUND - roundIndex;

   // Mirror read port for decryption order, same latency as roundKey.
   always_ff @(posedge clock) begin
      if (reset) begin
         invRoundKey <= '0;
      end else if (roundIndex <= LAST_ROUND) begin
         invRoundKey <= bank[inv_index];
      end else begin
         invRoundKey <= '0;
      end
   end
`endif

endmodule
